cpu_writeback_arb: RTL and testbench
====================================

CPU_WRITEBACK_ARB -- requirements
Module: cpu_writeback_arb

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, the number of memory return channels (1..4).
REQ-002 SHALL have parameter QDEPTH, default 4, the per-channel return FIFO depth (power of two, 2..8).
REQ-003 SHALL have parameter STARVE_LIM, default 8, the cycles a non-empty FIFO may wait before a forced bubble (1..255).
REQ-004 SHALL have parameter XLEN, default 32, the result width.
REQ-005 SHALL have port clock, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port p4_op, input, 6, the ALU-stage opcode.
REQ-008 SHALL have port p4_dest, input, 5, the ALU-stage destination register.
REQ-009 SHALL have port p4_dest_zero, input, 1, meaning the ALU-stage slot is free (destination x0).
REQ-010 SHALL have ports p4_alu_result and p4_mult_result, inputs, XLEN each, the ALU and multiplier results.
REQ-011 SHALL have port mem_valid, input, NUM_CH, the per-channel load-return valid.
REQ-012 SHALL have port mem_ready, output, NUM_CH, meaning the channel FIFO can accept.
REQ-013 SHALL have port mem_dest, input, 5*NUM_CH, the per-channel destination register, with channel i at bits [5i+4:5i].
REQ-014 SHALL have port mem_result, input, XLEN*NUM_CH, the per-channel load data.
REQ-015 SHALL have port p5u_write, output, 1, the register-file write enable, valid before the clock edge.
REQ-016 SHALL have ports p5u_dest_reg (5) and p5u_result (XLEN), outputs, the pre-edge write address and data.
REQ-017 SHALL have ports p5_result (XLEN), p5_is_mem_read (1) and p5_mem_chan (clog2(NUM_CH), min 1), outputs, registered copies for bypass and debug.
REQ-018 SHALL have port stall_req, output, 1, a request to the front end to inject a bubble.

Function
REQ-019 A channel i handshake SHALL occur when mem_valid[i] && mem_ready[i]; the FIFO SHALL push {mem_dest, mem_result} on that edge.
REQ-020 mem_ready[i] SHALL equal !full[i], with no same-cycle push-through when the FIFO is full, even if it pops that cycle.
REQ-021 Returns with mem_dest==0 SHALL be accepted and discarded without being enqueued.
REQ-022 When p4_dest_zero=0: p5u_write=1, p5u_dest_reg=p4_dest, and p5u_result=p4_mult_result if p4_op==OP_MUL, else p4_alu_result; no FIFO SHALL pop.
REQ-023 When p4_dest_zero=1 and some FIFO is non-empty: the module SHALL pop the head of the round-robin-selected FIFO and drive p5u_write=1 with its dest and result.
REQ-024 When p4_dest_zero=1 and all FIFOs are empty: p5u_write=0, p5u_dest_reg=0, p5u_result=0.
REQ-025 Round-robin: the search SHALL start at the channel after the last one served (wrapping NUM_CH-1 to 0); the pointer SHALL advance only on a pop.
REQ-026 Minimum latency SHALL be 1 cycle: data accepted at edge N is writable at the earliest before edge N+1.
REQ-027 FIFO pointers SHALL be clog2(QDEPTH)+1 bits wide; full = MSBs differ and LSBs equal; empty = pointers equal.
REQ-028 Per channel, a starve counter SHALL increment each cycle the FIFO is non-empty and not popped, saturate at STARVE_LIM, and clear on a pop or when empty.
REQ-029 stall_req SHALL be registered and SHALL assert the cycle after any starve counter reaches STARVE_LIM or any FIFO is full; it SHALL deassert the cycle after no counter is at the limit and no FIFO is full.
REQ-030 On each edge: p5_result<=p5u_result, p5_is_mem_read<=(pop occurred), p5_mem_chan<=channel popped (else hold).
REQ-031 p5u_* SHALL be combinational from current state and p4_* inputs only, with no path from mem_valid.

Reset
REQ-032 While reset=0: FIFOs empty, pointers 0, RR pointer 0 (channel 0 first), starve counters 0, stall_req=0, p5_result=0, p5_is_mem_read=0, p5_mem_chan=0, and mem_ready all ones only after release.
REQ-033 Reset asserted mid-operation SHALL discard all queued returns immediately and asynchronously.

Verification
REQ-034 p4_dest=7, dest_zero=0, op=OP_MUL, mult=0x12345678 -> p5u_write=1, dest 7, result 0x12345678; next cycle p5_result=0x12345678.
REQ-035 Ch0 pushes (r3,0xAA) at edge N; dest_zero=1 at N+1 -> p5u_dest_reg=3, result 0xAA, p5_is_mem_read=1 after N+1.
REQ-036 Ch0 and ch1 each hold 2 entries, dest_zero=1 for 4 cycles -> pop order ch0,ch1,ch0,ch1.
REQ-037 QDEPTH=4, 4 pushes to ch1 with no free slot -> mem_ready[1]=0 after the 4th and stall_req=1 the next cycle; one free slot -> mem_ready[1]=1.
REQ-038 STARVE_LIM=3, ch0 non-empty, dest_zero held 0 -> stall_req rises on the 4th cycle and falls the cycle after the pop.
REQ-039 Reset driven low with 3 queued entries -> mem_ready all ones after release, p5u_write=0 with dest_zero=1.

Source files
------------

// File: rtl/cpu_writeback_arb.sv
// Writeback-stage arbiter: merges ALU/multiplier results with queued load returns
// from NUM_CH memory channels, filling free writeback slots round-robin.
module cpu_writeback_arb #(
    parameter int         NUM_CH     = 2,
    parameter int         QDEPTH     = 4,
    parameter int         STARVE_LIM = 8,
    parameter int         XLEN       = 32,
    parameter logic [5:0] OP_MUL     = 6'h18
) (
    input  logic                                           clock,
    input  logic                                           reset,
    input  logic [5:0]                                     p4_op,
    input  logic [4:0]                                     p4_dest,
    input  logic                                           p4_dest_zero,
    input  logic [XLEN-1:0]                                p4_alu_result,
    input  logic [XLEN-1:0]                                p4_mult_result,
    input  logic [NUM_CH-1:0]                              mem_valid,
    output logic [NUM_CH-1:0]                              mem_ready,
    input  logic [5*NUM_CH-1:0]                            mem_dest,
    input  logic [XLEN*NUM_CH-1:0]                         mem_result,
    output logic                                           p5u_write,
    output logic [4:0]                                     p5u_dest_reg,
    output logic [XLEN-1:0]                                p5u_result,
    output logic [XLEN-1:0]                                p5_result,
    output logic                                           p5_is_mem_read,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] p5_mem_chan,
    output logic                                           stall_req
);

    localparam int         AW      = $clog2(QDEPTH);
    localparam int         CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [7:0] LIM     = 8'(STARVE_LIM);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    localparam logic [CW-1:0] CH_ONE = CW'(1);

    logic [NUM_CH-1:0]           full;
    logic [NUM_CH-1:0]           empty;
    logic [NUM_CH-1:0]           at_lim;
    logic [NUM_CH-1:0]           push;
    logic [NUM_CH-1:0]           pop;
    logic [NUM_CH-1:0][4:0]      head_dest;
    logic [NUM_CH-1:0][XLEN-1:0] head_data;
    logic [CW-1:0]               rr_ptr;
    logic [CW-1:0]               sel;
    logic                        found;
    logic                        pop_any;
    logic                        rdy_en;
    int                          idx;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v >= LIM) ? LIM : v + 8'd1;
    endfunction

    // rdy_en keeps every channel closed until the first edge after reset release
    assign mem_ready = ~full & {NUM_CH{rdy_en}};
    assign pop_any   = p4_dest_zero && found;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [4:0]      dst_mem [QDEPTH];
        logic [XLEN-1:0] dat_mem [QDEPTH];
        logic [AW:0]     wr_ptr;
        logic [AW:0]     rd_ptr;
        logic [7:0]      starve;

        assign full[g]      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        assign empty[g]     = (wr_ptr == rd_ptr);
        assign at_lim[g]    = (starve == LIM);
        // x0 returns complete the handshake but never occupy a slot
        assign push[g]      = mem_valid[g] && !full[g] && rdy_en && (mem_dest[5*g +: 5] != 5'd0);
        assign pop[g]       = pop_any && (sel == CW'(g));
        assign head_dest[g] = dst_mem[rd_ptr[AW-1:0]];
        assign head_data[g] = dat_mem[rd_ptr[AW-1:0]];

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                starve <= '0;
            end else begin
                if (push[g]) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop[g])  rd_ptr <= rd_ptr + PTR_ONE;
                if (empty[g] || pop[g]) starve <= '0;
                else                    starve <= sat_inc(starve);
            end
        end

        always_ff @(posedge clock) begin
            if (push[g]) begin
                dst_mem[wr_ptr[AW-1:0]] <= mem_dest[5*g +: 5];
                dat_mem[wr_ptr[AW-1:0]] <= mem_result[XLEN*g +: XLEN];
            end
        end
    end

    // Round-robin search starting at rr_ptr, the channel after the last one served
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && !empty[idx[CW-1:0]]) begin
                found = 1'b1;
                sel   = idx[CW-1:0];
            end
        end
    end

    always_comb begin
        p5u_write    = 1'b0;
        p5u_dest_reg = '0;
        p5u_result   = '0;
        if (!p4_dest_zero) begin
            p5u_write    = 1'b1;
            p5u_dest_reg = p4_dest;
            p5u_result   = (p4_op == OP_MUL) ? p4_mult_result : p4_alu_result;
        end else if (found) begin
            p5u_write    = 1'b1;
            p5u_dest_reg = head_dest[sel];
            p5u_result   = head_data[sel];
        end
    end

    // Stage 5 registers: bypass copy, arbitration pointer and stall request
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdy_en         <= 1'b0;
            rr_ptr         <= '0;
            stall_req      <= 1'b0;
            p5_result      <= '0;
            p5_is_mem_read <= 1'b0;
            p5_mem_chan    <= '0;
        end else begin
            rdy_en         <= 1'b1;
            stall_req      <= (|at_lim) || (|full);
            p5_result      <= p5u_result;
            p5_is_mem_read <= pop_any;
            if (pop_any) begin
                p5_mem_chan <= sel;
                rr_ptr      <= (int'(sel) == NUM_CH - 1) ? '0 : sel + CH_ONE;
            end
        end
    end

endmodule

// File: tb/tb_cpu_writeback_arb.sv
// Directed and randomized bench for cpu_writeback_arb, checked against a
// queue-based model of the writeback arbitration rules.
module tb_cpu_writeback_arb;

    localparam int         NUM_CH     = 2;
    localparam int         QDEPTH     = 4;
    localparam int         STARVE_LIM = 3;
    localparam int         XLEN       = 32;
    localparam logic [5:0] OP_MUL     = 6'h18;

    logic                     clock = 1'b0;
    logic                     reset;
    logic [5:0]               p4_op;
    logic [4:0]               p4_dest;
    logic                     p4_dest_zero;
    logic [XLEN-1:0]          p4_alu_result;
    logic [XLEN-1:0]          p4_mult_result;
    logic [NUM_CH-1:0]        mem_valid;
    logic [NUM_CH-1:0]        mem_ready;
    logic [5*NUM_CH-1:0]      mem_dest;
    logic [XLEN*NUM_CH-1:0]   mem_result;
    logic                     p5u_write;
    logic [4:0]               p5u_dest_reg;
    logic [XLEN-1:0]          p5u_result;
    logic [XLEN-1:0]          p5_result;
    logic                     p5_is_mem_read;
    logic [0:0]               p5_mem_chan;
    logic                     stall_req;

    cpu_writeback_arb #(
        .NUM_CH(NUM_CH), .QDEPTH(QDEPTH), .STARVE_LIM(STARVE_LIM), .XLEN(XLEN), .OP_MUL(OP_MUL)
    ) dut (
        .clock(clock), .reset(reset),
        .p4_op(p4_op), .p4_dest(p4_dest), .p4_dest_zero(p4_dest_zero),
        .p4_alu_result(p4_alu_result), .p4_mult_result(p4_mult_result),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_result(mem_result),
        .p5u_write(p5u_write), .p5u_dest_reg(p5u_dest_reg), .p5u_result(p5u_result),
        .p5_result(p5_result), .p5_is_mem_read(p5_is_mem_read), .p5_mem_chan(p5_mem_chan),
        .stall_req(stall_req)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: one queue of {dest, data} per channel
    logic [36:0]     q0[$];
    logic [36:0]     q1[$];
    int              mrr;
    int              mstarve [NUM_CH];
    logic            mstall;
    logic [XLEN-1:0] mp5_res;
    logic            mp5_mem;
    logic [0:0]      mp5_chan;
    logic            mrdy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        mrr = 0;
        for (int c = 0; c < NUM_CH; c++) mstarve[c] = 0;
        mstall   = 1'b0;
        mp5_res  = '0;
        mp5_mem  = 1'b0;
        mp5_chan = '0;
        mrdy     = 1'b0;
    endtask

    // Check one cycle at the falling edge, then advance the model across the rising edge
    task automatic step();
        int              sz [NUM_CH];
        logic [NUM_CH-1:0] erdy;
        int              sel;
        int              c;
        logic            ew;
        logic [4:0]      ed;
        logic [XLEN-1:0] er;
        logic [36:0]     ent;
        logic            nstall;
        @(negedge clock);
        sz[0] = q0.size();
        sz[1] = q1.size();
        for (int k = 0; k < NUM_CH; k++) erdy[k] = mrdy && (sz[k] < QDEPTH);
        sel = -1; ew = 1'b0; ed = '0; er = '0;
        if (!p4_dest_zero) begin
            ew = 1'b1;
            ed = p4_dest;
            er = (p4_op == OP_MUL) ? p4_mult_result : p4_alu_result;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                c = (mrr + k) % NUM_CH;
                if (sel < 0 && sz[c] > 0) sel = c;
            end
            if (sel >= 0) begin
                ent = (sel == 0) ? q0[0] : q1[0];
                ew = 1'b1;
                ed = ent[36:32];
                er = ent[31:0];
            end
        end
        chk("p5u_write",      64'(p5u_write),      64'(ew));
        chk("p5u_dest_reg",   64'(p5u_dest_reg),   64'(ed));
        chk("p5u_result",     64'(p5u_result),     64'(er));
        chk("mem_ready",      64'(mem_ready),      64'(erdy));
        chk("stall_req",      64'(stall_req),      64'(mstall));
        chk("p5_result",      64'(p5_result),      64'(mp5_res));
        chk("p5_is_mem_read", 64'(p5_is_mem_read), 64'(mp5_mem));
        chk("p5_mem_chan",    64'(p5_mem_chan),    64'(mp5_chan));
        nstall = 1'b0;
        for (int k = 0; k < NUM_CH; k++)
            if (mstarve[k] == STARVE_LIM || sz[k] == QDEPTH) nstall = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sz[k] == 0 || k == sel) mstarve[k] = 0;
            else if (mstarve[k] < STARVE_LIM) mstarve[k] = mstarve[k] + 1;
        end
        if (sel == 0) void'(q0.pop_front());
        else if (sel == 1) void'(q1.pop_front());
        for (int k = 0; k < NUM_CH; k++) begin
            if (mem_valid[k] && erdy[k] && mem_dest[5*k +: 5] != 5'd0) begin
                if (k == 0) q0.push_back({mem_dest[4:0], mem_result[31:0]});
                else        q1.push_back({mem_dest[9:5], mem_result[63:32]});
            end
        end
        if (sel >= 0) begin
            mrr      = (sel + 1) % NUM_CH;
            mp5_mem  = 1'b1;
            mp5_chan = 1'(sel);
        end else begin
            mp5_mem = 1'b0;
        end
        mp5_res = er;
        mstall  = nstall;
        mrdy    = 1'b1;
        @(posedge clock);
        #1;
    endtask

    logic [4:0] ord [4] = '{5'd1, 5'd4, 5'd2, 5'd5};

    initial begin
        reset = 1'b0;
        p4_op = '0; p4_dest = '0; p4_dest_zero = 1'b1;
        p4_alu_result = '0; p4_mult_result = '0;
        mem_valid = '0; mem_dest = '0; mem_result = '0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        chk("rst_mem_ready",  64'(mem_ready),      64'(0));
        chk("rst_stall",      64'(stall_req),      64'(0));
        chk("rst_p5_result",  64'(p5_result),      64'(0));
        chk("rst_p5_memrd",   64'(p5_is_mem_read), 64'(0));
        chk("rst_p5_chan",    64'(p5_mem_chan),    64'(0));
        chk("rst_p5u_write",  64'(p5u_write),      64'(0));
        chk("rst_p5u_dest",   64'(p5u_dest_reg),   64'(0));
        chk("rst_p5u_result", 64'(p5u_result),     64'(0));
        reset = 1'b1;
        step();

        // ALU slot occupied by a multiply
        p4_dest_zero = 1'b0; p4_dest = 5'd7; p4_op = OP_MUL;
        p4_mult_result = 32'h12345678; p4_alu_result = 32'hDEADBEEF;
        #1;
        chk("mul_write",  64'(p5u_write),    64'(1));
        chk("mul_dest",   64'(p5u_dest_reg), 64'(7));
        chk("mul_result", 64'(p5u_result),   64'h12345678);
        step();
        p4_dest_zero = 1'b1;
        chk("mul_p5_result", 64'(p5_result), 64'h12345678);
        step();

        // Two entries per channel, drained in alternating order
        p4_dest_zero = 1'b0; p4_op = 6'd0; p4_dest = 5'd2;
        mem_valid = 2'b11; mem_dest = {5'd4, 5'd1}; mem_result = {32'h200, 32'h100};
        step();
        mem_dest = {5'd5, 5'd2}; mem_result = {32'h201, 32'h101};
        step();
        mem_valid = '0; p4_dest_zero = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_order", 64'(p5u_dest_reg), 64'(ord[i]));
            step();
        end

        // Single return on channel 0, written back the next cycle
        mem_valid = 2'b01; mem_dest = {5'd0, 5'd3}; mem_result = {32'h0, 32'hAA};
        step();
        mem_valid = '0;
        #1;
        chk("lat_write",  64'(p5u_write),    64'(1));
        chk("lat_dest",   64'(p5u_dest_reg), 64'(3));
        chk("lat_result", 64'(p5u_result),   64'hAA);
        step();
        chk("lat_memrd", 64'(p5_is_mem_read), 64'(1));
        chk("lat_chan",  64'(p5_mem_chan),    64'(0));

        // Fill channel 1 while the ALU owns every slot
        p4_dest_zero = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_valid = 2'b10;
            mem_dest = {5'(10 + i), 5'd0};
            mem_result = {32'(32'h300 + i), 32'h0};
            step();
        end
        mem_valid = '0;
        chk("full_ready", 64'(mem_ready[1]), 64'(0));
        step();
        chk("full_stall", 64'(stall_req), 64'(1));
        p4_dest_zero = 1'b1;
        step();
        chk("free_ready", 64'(mem_ready[1]), 64'(1));
        repeat (5) step();

        // Starvation of channel 0 with the ALU never yielding
        p4_dest_zero = 1'b0; p4_dest = 5'd6;
        mem_valid = 2'b01; mem_dest = {5'd0, 5'd9}; mem_result = {32'h0, 32'h55};
        step();
        mem_valid = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("starve_low", 64'(stall_req), 64'(0));
        end
        step();
        chk("starve_high", 64'(stall_req), 64'(1));
        p4_dest_zero = 1'b1;
        step();
        step();
        chk("starve_clear", 64'(stall_req), 64'(0));

        // Reset in the middle of traffic with three queued entries
        p4_dest_zero = 1'b0;
        mem_valid = 2'b11; mem_dest = {5'd11, 5'd10}; mem_result = {32'h411, 32'h410};
        step();
        mem_valid = 2'b01; mem_dest = {5'd0, 5'd12}; mem_result = {32'h0, 32'h412};
        step();
        mem_valid = '0; p4_dest_zero = 1'b1;
        reset = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(mem_ready),      64'(0));
        chk("mid_rst_write", 64'(p5u_write),      64'(0));
        chk("mid_rst_memrd", 64'(p5_is_mem_read), 64'(0));
        chk("mid_rst_stall", 64'(stall_req),      64'(0));
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        step();
        chk("post_rst_ready", 64'(mem_ready), 64'(2'b11));
        chk("post_rst_write", 64'(p5u_write), 64'(0));

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            mem_valid = 2'($urandom);
            for (int c = 0; c < NUM_CH; c++) begin
                mem_dest[5*c +: 5] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                mem_result[XLEN*c +: XLEN] = $urandom;
            end
            p4_dest_zero   = ($urandom_range(0, 2) != 0);
            p4_op          = ($urandom_range(0, 1) == 0) ? OP_MUL : 6'($urandom);
            p4_dest        = 5'($urandom);
            p4_alu_result  = $urandom;
            p4_mult_result = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
